rf_scoreboard: RTL and testbench

Per-register hazard scoreboard that controls issue into the 8x16 bypassing register file. It tracks in-flight writes per architectural register and stalls the decode/issue stage on RAW hazards. When a pending write retires in the same cycle it is needed, it allows issue and steers the register file's write-before-read bypass instead of stalling. It sits between decode and the register file and is driven by the writeback stage.

---
 rtl/rf_scoreboard.sv | 156 +++++++++++++++
 tb/tb_rf_scoreboard.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard gating decode/issue into the bypassing register file.
// Optional stall/bypass statistics counters are built when RF_SCOREBOARD_STATS_EN is defined.
module rf_scoreboard #(
   parameter int NREG = 8,
   parameter int SELW = 3,
   parameter int CNTW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   input  logic            issue_wr,
   input  logic [SELW-1:0] issue_dst,
   input  logic            src1_use,
   input  logic [SELW-1:0] src1_sel,
   input  logic            src2_use,
   input  logic [SELW-1:0] src2_sel,
   input  logic            wb_valid,
   input  logic [SELW-1:0] wb_reg,
   input  logic            flush,
   output logic            stall,
   output logic            issue_fire,
   output logic            fwd1,
   output logic            fwd2,
   output logic [NREG-1:0] busy,
   output logic            err
`ifdef RF_SCOREBOARD_STATS_EN
   ,
   output logic [15:0]     stall_cycles,
   output logic [15:0]     bypass_cnt
`endif
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

   logic [CNTW-1:0] cnt_q [NREG];
   logic [CNTW-1:0] cnt_d [NREG];
   logic            err_q;
   logic            err_d;

   logic [CNTW-1:0] src1_cnt;
   logic [CNTW-1:0] src2_cnt;
   logic [CNTW-1:0] dst_cnt;
   logic [CNTW-1:0] wb_cnt;
   logic            wb_hit_src1;
   logic            wb_hit_src2;
   logic            wb_hit_dst;
   logic            src1_ready;
   logic            src2_ready;
   logic            dst_full;
   logic [NREG-1:0] inc_vec;
   logic [NREG-1:0] dec_vec;

   assign src1_cnt = cnt_q[src1_sel];
   assign src2_cnt = cnt_q[src2_sel];
   assign dst_cnt  = cnt_q[issue_dst];
   assign wb_cnt   = cnt_q[wb_reg];

   assign wb_hit_src1 = wb_valid & (wb_reg == src1_sel);
   assign wb_hit_src2 = wb_valid & (wb_reg == src2_sel);
   assign wb_hit_dst  = wb_valid & (wb_reg == issue_dst);

   // A single outstanding write that retires this cycle is served by the RF bypass.
   assign src1_ready = (src1_cnt == '0) | ((src1_cnt == CNT_ONE) & wb_hit_src1);
   assign src2_ready = (src2_cnt == '0) | ((src2_cnt == CNT_ONE) & wb_hit_src2);
   assign dst_full   = (dst_cnt == CNT_MAX) & ~wb_hit_dst;

   assign stall = issue_valid & ((src1_use & ~src1_ready) |
                                 (src2_use & ~src2_ready) |
                                 (issue_wr & dst_full));

   assign issue_fire = issue_valid & ~stall;
   assign fwd1       = issue_valid & src1_use & (src1_cnt == CNT_ONE) & wb_hit_src1;
   assign fwd2       = issue_valid & src2_use & (src2_cnt == CNT_ONE) & wb_hit_src2;
   assign err        = err_q;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      busy    = '0;
      for (int i = 0; i < NREG; i++) begin
         inc_vec[i] = issue_fire & issue_wr & (issue_dst == SELW'(i));
         dec_vec[i] = wb_valid & (wb_reg == SELW'(i)) & (cnt_q[i] != '0);
         busy[i]    = (cnt_q[i] != '0);
      end
   end

   // Flush discards same-cycle issue/writeback accounting entirely.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
         if (flush) begin
            cnt_d[i] = '0;
         end else if (inc_vec[i] & ~dec_vec[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (dec_vec[i] & ~inc_vec[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
         end
      end
   end

   assign err_d = err_q | (wb_valid & ~flush & (wb_cnt == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         err_q <= err_d;
      end
   end

`ifdef RF_SCOREBOARD_STATS_EN
   logic [15:0] stall_cycles_q;
   logic [15:0] stall_cycles_d;
   logic [15:0] bypass_cnt_q;
   logic [15:0] bypass_cnt_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
      logic [15:0] r;
      r = v;
      if (en && (v != 16'hFFFF)) begin
         r = v + 16'd1;
      end
      return r;
   endfunction

   always_comb begin
      stall_cycles_d = sat_inc16(stall_cycles_q, stall);
      bypass_cnt_d   = sat_inc16(bypass_cnt_q, issue_fire & (fwd1 | fwd2));
      if (flush) begin
         stall_cycles_d = '0;
         bypass_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q <= '0;
         bypass_cnt_q   <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         bypass_cnt_q   <= bypass_cnt_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign bypass_cnt   = bypass_cnt_q;
`endif

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed plus randomized bench for rf_scoreboard against an array-based reference model.
module tb_rf_scoreboard;

   logic       clk;
   logic       rst;
   logic       issue_valid;
   logic       issue_wr;
   logic [2:0] issue_dst;
   logic       src1_use;
   logic [2:0] src1_sel;
   logic       src2_use;
   logic [2:0] src2_sel;
   logic       wb_valid;
   logic [2:0] wb_reg;
   logic       flush;
   logic       stall;
   logic       issue_fire;
   logic       fwd1;
   logic       fwd2;
   logic [7:0] busy;
   logic       err;
`ifdef RF_SCOREBOARD_STATS_EN
   logic [15:0] stall_cycles;
   logic [15:0] bypass_cnt;
`endif

   rf_scoreboard #(.NREG(8), .SELW(3), .CNTW(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_wr    (issue_wr),
      .issue_dst   (issue_dst),
      .src1_use    (src1_use),
      .src1_sel    (src1_sel),
      .src2_use    (src2_use),
      .src2_sel    (src2_sel),
      .wb_valid    (wb_valid),
      .wb_reg      (wb_reg),
      .flush       (flush),
      .stall       (stall),
      .issue_fire  (issue_fire),
      .fwd1        (fwd1),
      .fwd2        (fwd2),
      .busy        (busy),
      .err         (err)
`ifdef RF_SCOREBOARD_STATS_EN
      ,
      .stall_cycles(stall_cycles),
      .bypass_cnt  (bypass_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: outstanding write count per register, sticky error, statistics.
   int m_cnt [8];
   bit m_err;
   int m_stalls;
   int m_byp;
   bit e_stall, e_f1, e_f2, e_fire;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_err = 0;
      m_stalls = 0;
      m_byp = 0;
   endtask

   function automatic bit m_ready(input int s);
      return (m_cnt[s] == 0) || (m_cnt[s] == 1 && wb_valid && int'(wb_reg) == s);
   endfunction

   function automatic logic [7:0] m_busy();
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = (m_cnt[i] > 0);
      return b;
   endfunction

   task automatic model_eval();
      bit dst_blk;
      dst_blk = issue_wr && m_cnt[issue_dst] == 3 && !(wb_valid && wb_reg == issue_dst);
      e_stall = issue_valid && ((src1_use && !m_ready(int'(src1_sel))) ||
                                (src2_use && !m_ready(int'(src2_sel))) || dst_blk);
      e_f1 = issue_valid && src1_use && m_cnt[src1_sel] == 1 && wb_valid && wb_reg == src1_sel;
      e_f2 = issue_valid && src2_use && m_cnt[src2_sel] == 1 && wb_valid && wb_reg == src2_sel;
      e_fire = issue_valid && !e_stall;
   endtask

   task automatic model_commit();
      if (flush) begin
         for (int i = 0; i < 8; i++) m_cnt[i] = 0;
         m_stalls = 0;
         m_byp = 0;
      end else begin
         if (wb_valid) begin
            if (m_cnt[wb_reg] > 0) m_cnt[wb_reg]--;
            else m_err = 1;
         end
         if (e_fire && issue_wr) m_cnt[issue_dst]++;
         if (e_stall && m_stalls < 65535) m_stalls++;
         if (e_fire && (e_f1 || e_f2) && m_byp < 65535) m_byp++;
      end
   endtask

   task automatic drive(input bit iv, input bit wr, input int dst, input bit u1, input int s1,
                        input bit u2, input int s2, input bit wv, input int wr_reg, input bit fl);
      issue_valid = iv;
      issue_wr    = wr;
      issue_dst   = 3'(dst);
      src1_use    = u1;
      src1_sel    = 3'(s1);
      src2_use    = u2;
      src2_sel    = 3'(s2);
      wb_valid    = wv;
      wb_reg      = 3'(wr_reg);
      flush       = fl;
   endtask

   // One clock: check combinational outputs, clock, then check registered state.
   task automatic cyc(input string tag);
      #1;
      model_eval();
      chk({tag, ".stall"}, 16'(stall), 16'(e_stall));
      chk({tag, ".fire"}, 16'(issue_fire), 16'(e_fire));
      chk({tag, ".fwd1"}, 16'(fwd1), 16'(e_f1));
      chk({tag, ".fwd2"}, 16'(fwd2), 16'(e_f2));
      @(posedge clk);
      model_commit();
      #1;
      chk({tag, ".busy"}, 16'(busy), 16'(m_busy()));
      chk({tag, ".err"}, 16'(err), 16'(m_err));
`ifdef RF_SCOREBOARD_STATS_EN
      chk({tag, ".stallcyc"}, stall_cycles, 16'(m_stalls));
      chk({tag, ".bypcnt"}, bypass_cnt, 16'(m_byp));
`endif
   endtask

   initial begin
      int pick;
      rst = 1'b0;
      drive(1, 1, 3, 1, 2, 1, 4, 0, 0, 0);
      model_reset();
      #2;
      chk("rst.busy", 16'(busy), 16'h00);
      chk("rst.stall", 16'(stall), 16'h0);
      chk("rst.err", 16'(err), 16'h0);
      chk("rst.fire", 16'(issue_fire), 16'h1);
      chk("rst.fwd", 16'({fwd1, fwd2}), 16'h0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // RAW hazard resolved through same-cycle writeback bypass
      drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
      cyc("raw_iss");
      drive(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
      #1;
      chk("raw.stall", 16'(stall), 16'h1);
      chk("raw.busy", 16'(busy), 16'h04);
      cyc("raw_s1");
      cyc("raw_s2");
      drive(1, 0, 0, 1, 2, 0, 0, 1, 2, 0);
      #1;
      chk("raw.fwd1", 16'(fwd1), 16'h1);
      chk("raw.nostall", 16'(stall), 16'h0);
      chk("raw.fire", 16'(issue_fire), 16'h1);
      cyc("raw_wb");
      chk("raw.busy_after", 16'(busy), 16'h00);

      // Issue and writeback of the same register in one cycle
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      cyc("same_a");
      drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
      #1;
      chk("same.fire", 16'(issue_fire), 16'h1);
      cyc("same_b");
      chk("same.busy", 16'(busy), 16'h20);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
      cyc("same_drain");
      chk("same.busy0", 16'(busy), 16'h00);

      // Counter saturation guarded by the destination-full stall
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc("sat_fill");
      chk("sat.busy", 16'(busy), 16'h02);
      #1;
      chk("sat.stall", 16'(stall), 16'h1);
      cyc("sat_full");
      drive(1, 1, 1, 0, 0, 0, 0, 1, 1, 0);
      #1;
      chk("sat.wbfire", 16'(issue_fire), 16'h1);
      cyc("sat_wb");
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("sat.still_full", 16'(stall), 16'h1);
      cyc("sat_hold");
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      for (int k = 0; k < 3; k++) cyc("sat_drain");
      chk("sat.busy0", 16'(busy), 16'h00);
      chk("sat.noerr", 16'(err), 16'h0);

      // Writeback with nothing pending
      drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
      cyc("uf_wb");
      chk("uf.err", 16'(err), 16'h1);
      chk("uf.busy", 16'(busy), 16'h00);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("uf_idle");
      chk("uf.err_sticky", 16'(err), 16'h1);

      // Flush with concurrent issue
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("fl_a");
      cyc("fl_b");
      drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
      cyc("fl_c");
      chk("fl.busy_pre", 16'(busy), 16'h11);
      drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 1);
      cyc("fl_flush");
      chk("fl.busy", 16'(busy), 16'h00);
`ifdef RF_SCOREBOARD_STATS_EN
      chk("fl.stallcyc", stall_cycles, 16'h0);
`endif

      // Asynchronous reset mid-cycle with pending writes
      drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      cyc("ar_a");
      cyc("ar_b");
      chk("ar.busy_pre", 16'(busy), 16'h08);
      drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("ar.busy", 16'(busy), 16'h00);
      chk("ar.stall", 16'(stall), 16'h0);
      chk("ar.err", 16'(err), 16'h0);
      chk("ar.fire", 16'(issue_fire), 16'h1);
      #2;
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      // Randomized traffic on a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         issue_valid = ($urandom_range(9) < 7);
         issue_wr    = ($urandom_range(3) != 0);
         issue_dst   = 3'($urandom_range(3));
         src1_use    = 1'($urandom_range(1));
         src1_sel    = 3'($urandom_range(3));
         src2_use    = 1'($urandom_range(1));
         src2_sel    = 3'($urandom_range(4));
         wb_valid    = ($urandom_range(9) < 6);
         pick        = int'($urandom_range(7));
         if ($urandom_range(9) != 0) begin
            for (int k = 0; k < 8; k++) begin
               if (m_cnt[(pick + k) % 8] > 0) begin
                  pick = (pick + k) % 8;
                  break;
               end
            end
         end
         wb_reg = 3'(pick);
         flush  = ($urandom_range(39) == 0);
         cyc("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
